// File: rtl/servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// servo_cmd_scheduler
//
// Queues 8-bit servo position commands, maps each to a PWM pulse width and
// slews the PWM duty toward that width by at most STEP clocks per PWM frame.
// Duty only changes on the last clock of a frame, so the PWM generator always
// sees whole frames at one width. Once a target is reached the position is
// held for DWELL_FRAMES frames before the next command is taken.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   cmd_valid   position command valid
//   cmd_pos     target position 0..255
//   cmd_ready   command accepted when high together with cmd_valid
//   flush       one-cycle pulse: drop queued commands and stop motion
//   duty_cycle  pulse width (clocks) to the PWM generator
//   frame_tick  high on the last clock of each PWM frame
//   busy        FSM not idle or queue non-empty
//   at_target   duty_cycle equals the current target
//   fifo_level  queued command count, 0..4
//
// Handshake: a command transfers on every rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on registered FIFO level,
// never on cmd_valid, and a same-cycle flush discards the transfer.
// -----------------------------------------------------------------------------
module servo_cmd_scheduler #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned PERIOD       = 500_000,
  parameter int unsigned MIN_DUTY     = 25_000,
  parameter int unsigned MAX_DUTY     = 50_000,
  parameter int unsigned STEP         = 500,
  parameter int unsigned DWELL_FRAMES = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_pos,
  output logic        cmd_ready,
  input  logic        flush,
  output logic [31:0] duty_cycle,
  output logic        frame_tick,
  output logic        busy,
  output logic        at_target,
  output logic [2:0]  fifo_level
);

  // Elaboration-time sanity checks on the parameter set.
  if (CLK_FREQ == 0) begin : g_bad_clk
    $error("CLK_FREQ must be non-zero");
  end
  if (!(MIN_DUTY < MAX_DUTY && MAX_DUTY <= PERIOD)) begin : g_bad_duty
    $error("need MIN_DUTY < MAX_DUTY <= PERIOD");
  end
  if (STEP < 1 || DWELL_FRAMES < 1) begin : g_bad_step
    $error("STEP and DWELL_FRAMES must be >= 1");
  end

  localparam logic [31:0] MID_DUTY = 32'(MIN_DUTY + (MAX_DUTY - MIN_DUTY) / 2);
  localparam logic [31:0] STEP_W   = 32'(STEP);
  localparam logic [31:0] LAST_CNT = 32'(PERIOD - 1);
  localparam logic [31:0] LAST_DW  = 32'(DWELL_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SLEW  = 2'd2,
    DWELL = 2'd3
  } state_t;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t state, next_state;

  logic [31:0] fcnt;
  logic        tick;

  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        push, pop;

  logic [31:0] duty, next_duty;
  logic [31:0] target, next_target;
  logic [31:0] dwell_cnt, next_dwell;

  logic [7:0]  head;
  logic [39:0] prod;
  logic [31:0] map_duty;
  logic [31:0] diff;

  // ---------------------------------------------------------------------------
  // Frame counter
  // ---------------------------------------------------------------------------
  assign tick = (fcnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (tick) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO (depth 4). Flush drops both the queue and any same-cycle push.
  // ---------------------------------------------------------------------------
  assign cmd_ready = (count != 3'd4);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign pop       = (state == LOAD) && (count != 3'd0) && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd_pos;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position -> pulse width. Position 255 is pinned to MAX_DUTY because the
  // /256 scaling would otherwise fall just short of it.
  // ---------------------------------------------------------------------------
  assign head     = mem[rd_ptr];
  assign prod     = 40'(head) * 40'(MAX_DUTY - MIN_DUTY);
  assign map_duty = (head == 8'd255) ? 32'(MAX_DUTY)
                                     : 32'(MIN_DUTY) + 32'(prod >> 8);

  // Distance to target; direction chosen in the FSM.
  assign diff = (target > duty) ? (target - duty) : (duty - target);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= MID_DUTY;
      target    <= MID_DUTY;
      dwell_cnt <= '0;
    end else begin
      state     <= next_state;
      duty      <= next_duty;
      target    <= next_target;
      dwell_cnt <= next_dwell;
    end
  end

  always_comb begin
    next_state  = state;
    next_duty   = duty;
    next_target = target;
    next_dwell  = dwell_cnt;

    case (state)
      IDLE: begin
        if (count != 3'd0) next_state = LOAD;
      end

      LOAD: begin
        next_target = map_duty;
        next_dwell  = '0;
        next_state  = (map_duty == duty) ? DWELL : SLEW;
      end

      SLEW: begin
        if (tick) begin
          if (diff <= STEP_W) begin
            next_duty  = target;
            next_dwell = '0;
            next_state = DWELL;
          end else if (target > duty) begin
            next_duty = duty + STEP_W;
          end else begin
            next_duty = duty - STEP_W;
          end
        end
      end

      DWELL: begin
        if (tick) begin
          if (dwell_cnt == LAST_DW) begin
            next_dwell = '0;
            next_state = (count != 3'd0) ? LOAD : IDLE;
          end else begin
            next_dwell = dwell_cnt + 32'd1;
          end
        end
      end

      default: next_state = IDLE;
    endcase

    // Flush freezes the output where it is and overrides any tick update.
    if (flush) begin
      next_state  = IDLE;
      next_duty   = duty;
      next_target = duty;
      next_dwell  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign duty_cycle = duty;
  assign frame_tick = tick;
  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != 3'd0);
  assign at_target  = (duty == target);

endmodule
